// File: rtl/fetchq_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Holds the redirect FSM state type and the fetch-word byte swap.
package fetchq_pkg;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } fq_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// Circular buffer for fetched {instruction, pc} entries.
// Flush empties it in one cycle; the caller never writes when full.
module fetchq_fifo
    import fetchq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/riscv_fetch_queue.sv
// Fetch PC generator, redirect FSM and instruction queue front end.
// Define FETCHQ_PERF_EN to add saturating empty/redirect perf counters.
module riscv_fetch_queue
    import fetchq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              icache_ren,
    output logic [ADDR_W-3:0] icache_addr,
    input  logic              icache_stall,
    input  logic [31:0]       icache_rdata,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       instr_o,
`ifdef FETCHQ_PERF_EN
    output logic [31:0]       perf_empty_cnt,
    output logic [31:0]       perf_redirect_cnt,
`endif
    output logic [ADDR_W-1:0] pc_o
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam int            EW   = 32 + ADDR_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fq_state_e         state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic [CW-1:0]     count;
    logic [EW-1:0]     rd_entry;
    logic              fetch;
    logic              pop;

    assign icache_ren  = (count < FULL) || (state_q == REDIR_PEND);
    assign icache_addr = fetch_pc_q[ADDR_W-1:2];
    assign valid_o     = (count != '0);
    assign fetch       = icache_ren && !icache_stall &&
                         (state_q == RUN) && !redirect_i;
    assign pop         = valid_o && ready_i && !redirect_i;

    assign instr_o = rd_entry[EW-1:ADDR_W];
    assign pc_o    = rd_entry[ADDR_W-1:0];

    fetchq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (redirect_i),
        .wr_en   (fetch),
        .wr_data ({bswap32(icache_rdata), fetch_pc_q}),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .count   (count)
    );

    // A word returning with a redirect, or after one, is always dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
        end else begin
            unique case (1'b1)
                redirect_i && icache_stall: begin
                    state_q   <= REDIR_PEND;
                    pend_pc_q <= redirect_pc_i;
                end
                redirect_i && !icache_stall: begin
                    state_q    <= RUN;
                    fetch_pc_q <= redirect_pc_i;
                end
                !redirect_i && (state_q == REDIR_PEND) && !icache_stall: begin
                    state_q    <= RUN;
                    fetch_pc_q <= pend_pc_q;
                end
                fetch: begin
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

`ifdef FETCHQ_PERF_EN
    logic [31:0] empty_cnt_q;
    logic [31:0] redir_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            empty_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (!valid_o && !redirect_i && (empty_cnt_q != '1)) begin
                empty_cnt_q <= empty_cnt_q + 32'd1;
            end
            if (redirect_i && (redir_cnt_q != '1)) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign perf_empty_cnt    = empty_cnt_q;
    assign perf_redirect_cnt = redir_cnt_q;
`endif

endmodule
